// File: rtl/counter_pkg.sv
// Shared encodings for the mode counter: FSM state values and count direction.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

endpackage

// File: rtl/mode_counter_next.sv
// Next-count arithmetic at WIDTH+1 bits plus terminal detection for one step.
module mode_counter_next
  import counter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic [WIDTH-1:0]  count,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  limit,
  input  logic              up,
  output logic [WIDTH:0]    nxt,
  output logic              term
);

  logic [WIDTH:0] count_x;
  logic [WIDTH:0] step_x;
  logic [WIDTH:0] limit_x;

  assign count_x = {1'b0, count};
  assign step_x  = (WIDTH+1)'(step);
  assign limit_x = {1'b0, limit};

  // A zero step never terminates, even when count already sits above limit.
  always_comb begin
    nxt  = count_x;
    term = 1'b0;
    if (up == DIR_UP) begin
      nxt  = count_x + step_x;
      term = (step_x != '0) && (nxt > limit_x);
    end else begin
      nxt  = count_x - step_x;
      term = (count_x < step_x);
    end
  end

endmodule

// File: rtl/mode_counter.sv
// Programmable up/down burst counter with auto-reload or one-shot terminal behaviour.
// state | meaning
// IDLE  | after reset, waiting for the first ld; count held
// RUN   | counting by step on each enabled cycle
// DONE  | one-shot terminal reached; count held, done sticky until ld
module mode_counter
  import counter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic              en,
  input  logic              up,
  input  logic              oneshot,
  input  logic [WIDTH-1:0]  start_seq,
  input  logic [WIDTH-1:0]  limit,
  input  logic [STEP_W-1:0] step,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic              busy,
  output logic              done
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic [WIDTH:0]   nxt;
  logic             term;
  logic             term_any;

  mode_counter_next #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_next (
    .count (count_q),
    .step  (step),
    .limit (limit),
    .up    (up),
    .nxt   (nxt),
    .term  (term)
  );

  // A carry/borrow out of the count width can only happen on a terminal step.
  assign term_any = term | nxt[WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
    if (ld) begin
      state_d = RUN;
      count_d = start_seq;
    end else if (state_q == RUN && en) begin
      if (term_any) begin
        tc_d = 1'b1;
        if (!oneshot) begin
          count_d = start_seq;
        end else begin
          state_d = DONE;
          count_d = (up == DIR_UP) ? limit : '0;
        end
      end else begin
        count_d = nxt[WIDTH-1:0];
      end
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_mode_counter.sv
// Directed bench for mode_counter: reset, reload, one-shot, load priority, step zero, boundary and async reset.
module tb_mode_counter;

  localparam int WIDTH  = 8;
  localparam int STEP_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              ld;
  logic              en;
  logic              up;
  logic              oneshot;
  logic [WIDTH-1:0]  start_seq;
  logic [WIDTH-1:0]  limit;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  count;
  logic              tc;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;

  mode_counter #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .ld        (ld),
    .en        (en),
    .up        (up),
    .oneshot   (oneshot),
    .start_seq (start_seq),
    .limit     (limit),
    .step      (step),
    .count     (count),
    .tc        (tc),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [7:0] e_count, input logic e_tc,
                           input logic e_busy, input logic e_done);
    check({tag, ".count"}, 32'(count), 32'(e_count));
    check({tag, ".tc"},    32'(tc),    32'(e_tc));
    check({tag, ".busy"},  32'(busy),  32'(e_busy));
    check({tag, ".done"},  32'(done),  32'(e_done));
  endtask

  logic [7:0] up_exp [8] = '{8'd5, 8'd7, 8'd9, 8'd3, 8'd5, 8'd7, 8'd9, 8'd3};
  logic       up_tc  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    rst = 1'b1; ld = 1'b0; en = 1'b0; up = 1'b1; oneshot = 1'b0;
    start_seq = '0; limit = '0; step = '0;

    // Reset held for 5 cycles, then enable without load
    for (int i = 0; i < 5; i++) begin
      tick();
      check_all("reset", 8'd0, 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b0;
    en  = 1'b1; step = 4'd1; limit = 8'd50;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_all("idle_en", 8'd0, 1'b0, 1'b0, 1'b0);
    end

    // Up, auto-reload: 3,5,7,9,3(tc)...
    en = 1'b0; ld = 1'b1; start_seq = 8'd3; limit = 8'd10; step = 4'd2; up = 1'b1; oneshot = 1'b0;
    tick();
    check_all("up_load", 8'd3, 1'b0, 1'b1, 1'b0);
    ld = 1'b0; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_all("up_reload", up_exp[i], up_tc[i], 1'b1, 1'b0);
    end
    en = 1'b0;
    tick();
    check_all("up_hold_en0", 8'd3, 1'b0, 1'b1, 1'b0);

    // Down, one-shot: 7,4,1,0(tc) then DONE
    ld = 1'b1; start_seq = 8'd7; step = 4'd3; up = 1'b0; oneshot = 1'b1;
    tick();
    check_all("dn_load", 8'd7, 1'b0, 1'b1, 1'b0);
    ld = 1'b0; en = 1'b1;
    tick(); check_all("dn_4", 8'd4, 1'b0, 1'b1, 1'b0);
    tick(); check_all("dn_1", 8'd1, 1'b0, 1'b1, 1'b0);
    tick(); check_all("dn_term", 8'd0, 1'b1, 1'b0, 1'b1);
    tick(); check_all("dn_done", 8'd0, 1'b0, 1'b0, 1'b1);
    up = 1'b1; limit = 8'd0;
    tick(); check_all("dn_done_live", 8'd0, 1'b0, 1'b0, 1'b1);
    en = 1'b0;
    tick(); check_all("dn_done_en0", 8'd0, 1'b0, 1'b0, 1'b1);
    ld = 1'b1; up = 1'b0; start_seq = 8'd7;
    tick(); check_all("dn_reload", 8'd7, 1'b0, 1'b1, 1'b0);

    // Load priority over enable, then step = 0 holds even above limit
    ld = 1'b1; en = 1'b1; start_seq = 8'd20; step = 4'd5; up = 1'b1; oneshot = 1'b0; limit = 8'd100;
    tick(); check_all("ld_prio", 8'd20, 1'b0, 1'b1, 1'b0);
    ld = 1'b0; step = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) limit = 8'd5;
      tick();
      check_all("step0", 8'd20, 1'b0, 1'b1, 1'b0);
    end
    step = 4'd1;
    tick(); check_all("above_limit", 8'd20, 1'b1, 1'b1, 1'b0);

    // Boundary: start = limit = 255, back-to-back terminal pulses
    ld = 1'b1; start_seq = 8'd255; limit = 8'd255; step = 4'd1; up = 1'b1; oneshot = 1'b0;
    tick(); check_all("bnd_load", 8'd255, 1'b0, 1'b1, 1'b0);
    ld = 1'b0;
    tick(); check_all("bnd_term1", 8'd255, 1'b1, 1'b1, 1'b0);
    tick(); check_all("bnd_term2", 8'd255, 1'b1, 1'b1, 1'b0);

    // One-shot up stops at limit
    ld = 1'b1; start_seq = 8'd250; limit = 8'd252; step = 4'd2; oneshot = 1'b1;
    tick(); check_all("up1_load", 8'd250, 1'b0, 1'b1, 1'b0);
    ld = 1'b0;
    tick(); check_all("up1_252", 8'd252, 1'b0, 1'b1, 1'b0);
    tick(); check_all("up1_term", 8'd252, 1'b1, 1'b0, 1'b1);

    // Async reset mid-run between edges
    ld = 1'b1; start_seq = 8'd0; limit = 8'd255; step = 4'd1; oneshot = 1'b0;
    tick(); check_all("rst_load", 8'd0, 1'b0, 1'b1, 1'b0);
    ld = 1'b0;
    tick(); tick(); tick();
    check_all("rst_pre", 8'd3, 1'b0, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 check_all("rst_async", 8'd0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    tick(); check_all("rst_after", 8'd0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mode_counter.md
# mode_counter

Parametrised successor to the team's 8-bit load/enable counter, used for burst-length and address sequencing in the memory-to-memory transfer datapath. It adds programmable width, step size, up/down direction and an upper limit. It also adds two terminal behaviours: auto-reload from `start_seq`, or one-shot stop with a sticky `done`. The control FSM runs the counter only after an explicit load.

## Interface
Parameters:
- `WIDTH`, 8: count, load and limit width.
- `STEP_W`, 4: width of the step increment.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ld`  in  1  load `start_seq` into count and enter RUN.
- `en`  in  1  count enable, effective only in RUN.
- `up`  in  1  1 = count up toward `limit`, 0 = count down toward 0.
- `oneshot`  in  1  1 = stop at terminal, 0 = auto-reload from `start_seq`.
- `start_seq`  in  WIDTH  load/reload value.
- `limit`  in  WIDTH  inclusive upper bound for up-counting.
- `step`  in  STEP_W  increment/decrement amount, zero-extended.
- `count`  out  WIDTH  current count (registered).
- `tc`  out  1  one-cycle terminal-count pulse (registered).
- `busy`  out  1  high while in RUN.
- `done`  out  1  sticky, high in DONE.

## Operation
- **Reset (async):**
  - state = IDLE
  - `count` = 0, `tc` = 0, `busy` = 0, `done` = 0
- **FSM states:** IDLE, RUN, DONE.
  - IDLE → RUN on `ld`.
  - RUN → DONE on terminal event when `oneshot` = 1.
  - DONE → RUN on `ld`.
  - No other transitions.
- **Load:** `ld` in any state sets `count` ← `start_seq`, state ← RUN, `done` ← 0, `tc` ← 0. `ld` has priority over `en`.
- **Counting:** in RUN with `en` = 1 and `ld` = 0, compute `nxt` at WIDTH+1 bits.
  - Up: `nxt` = `count` + `step`. Terminal if `nxt` > `limit`.
  - Down: terminal if `count` < `step`, otherwise `nxt` = `count` − `step`.
  - Non-terminal: `count` ← `nxt`, `tc` ← 0.
- **Terminal event:**
  - `tc` ← 1 for exactly one cycle.
  - If `oneshot` = 0: `count` ← `start_seq`, stay in RUN.
  - If `oneshot` = 1 and up: `count` ← `limit`, state ← DONE.
  - If `oneshot` = 1 and down: `count` ← 0, state ← DONE.
- **`step` = 0:** `count` holds and no terminal event occurs, even if `count` > `limit`.
- **Hold conditions:** `en` = 0, IDLE or DONE: `count` holds, `tc` = 0.
- **Live sampling:** `limit`, `up`, `oneshot` and `step` are sampled every enabled cycle, so mid-run changes take effect on the next step.
- **`start_seq` > `limit` on load (up mode):** allowed. The first enabled step is terminal.
- **`done` in DONE:** stays asserted regardless of `en`, `up` or `limit` until `ld` or `rst`.

## Timing
- All outputs are registered. A step requested by `en` at edge N is visible on `count`/`tc` after edge N.
- `tc` is high in the cycle after the terminal edge only; back-to-back terminal events give consecutive pulses.
- `busy` rises the cycle after the `ld` edge and falls with `done` rising.
- Reset mid-run clears outputs immediately, independent of `clk`. After reset is released, the first `ld` is needed before any counting.

## Structure
- Package `counter_pkg` holds:
  - state encoding: IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10
  - direction constants `DIR_DOWN`/`DIR_UP`
- One combinational sub-module, `mode_counter_next`:
  - inputs: `count`, `step`, `limit`, `up`
  - outputs: `nxt` and `term` (WIDTH+1-bit arithmetic)
- The top level holds the FSM and output registers.

## Test plan
- Reset/idle: `rst` high 5 cycles, then `en` = 1 without `ld` → `count` = 0, `busy` = 0, `tc` never asserted.
- Up, auto-reload: WIDTH = 8, `start_seq` = 3, `limit` = 10, `step` = 2, `up` = 1, `oneshot` = 0, `ld` then `en` → `count` 3, 5, 7, 9, then 3 with a single `tc` pulse, repeating.
- Down, one-shot: `start_seq` = 7, `step` = 3, `up` = 0, `oneshot` = 1 → `count` 7, 4, 1, then 0 with `tc` pulse. After that: `busy` = 0, `done` = 1, `count` holds 0 under `en`; a new `ld` clears `done`.
- Load priority and `step` = 0: `ld` and `en` together → `count` = `start_seq` with no step. Then `step` = 0 with `en` for 10 cycles → `count` holds, `tc` = 0.
- Boundary and reset: `start_seq` = 255, `limit` = 255, `step` = 1, up, auto-reload → first step is terminal, `count` = 255, `tc` = 1. `rst` asserted mid-run between clock edges → `count` = 0 immediately.
